cdc_event_throttle: RTL

// Fast-domain (clk1) front end for cdc_fast2slow: collects single-cycle event pulses at any rate,

---
 rtl/cdc_event_throttle_pkg.sv | 7 +
 rtl/cdc_event_throttle_if.sv | 24 ++
 rtl/cdc_sat_counter.sv | 32 +++
 rtl/cdc_event_throttle.sv | 77 +++++++
 4 files changed

// File: rtl/cdc_event_throttle_pkg.sv
// cdc_pkg: shared state encoding and counter-width helper for the event throttle
package cdc_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_RISE, WAIT_FALL} cdc_thr_state_e;
  function automatic int cnt_w(input int max);
    return $clog2(max + 1);
  endfunction
endpackage

// File: rtl/cdc_event_throttle_if.sv
// cdc_event_throttle_if: event/handshake/status bundle between the throttle and its environment
interface cdc_event_throttle_if
  import cdc_pkg::*;
#(
  parameter int MAX_PENDING = 15
);
  localparam int CNT_W = cnt_w(MAX_PENDING);
  logic             event_i;
  logic             cdc_busy_i;
  logic             clear_err_i;
  logic             data_o;
  logic [CNT_W-1:0] pending_o;
  logic             idle_o;
  logic             overflow_o;
  logic             ack_err_o;
  modport slave (
    input  event_i, cdc_busy_i, clear_err_i,
    output data_o, pending_o, idle_o, overflow_o, ack_err_o
  );
  modport master (
    output event_i, cdc_busy_i, clear_err_i,
    input  data_o, pending_o, idle_o, overflow_o, ack_err_o
  );
endinterface

// File: rtl/cdc_sat_counter.sv
// cdc_sat_counter: saturating up/down queue counter; an increment at full is dropped
module cdc_sat_counter
  import cdc_pkg::*;
#(
  parameter int MAX = 15,
  parameter int W   = cnt_w(MAX)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         full,
  output logic         empty,
  output logic         drop
);
  logic [W-1:0] cnt_q, cnt_d;
  assign full  = cnt_q == W'(MAX);
  assign empty = cnt_q == '0;
  assign drop  = inc && !dec && full;
  assign cnt   = cnt_q;
  // next count: simultaneous inc/dec cancel, saturate at MAX, never go below zero
  always_comb begin
    cnt_d = (inc && !dec && !full) ? cnt_q + W'(1) :
            (dec && !inc && !empty) ? cnt_q - W'(1) : cnt_q;
  end
  // counter register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
endmodule

// File: rtl/cdc_event_throttle.sv
// cdc_event_throttle: queues event pulses and forwards each as one toggle per busy handshake
module cdc_event_throttle
  import cdc_pkg::*;
#(
  parameter int MAX_PENDING = 15,
  parameter int RISE_WAIT   = 4
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  cdc_event_throttle_if.slave bus
);
  localparam int CNT_W = cnt_w(MAX_PENDING);
  localparam int TW    = RISE_WAIT > 1 ? $clog2(RISE_WAIT) : 1;
  cdc_thr_state_e state_q, state_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic           data_q, data_d;
  logic           ovf_q, ovf_d;
  logic           err_q, err_d;
  logic           issue, err_set, full, empty, drop;
  logic [CNT_W-1:0] cnt;
  cdc_sat_counter #(.MAX(MAX_PENDING), .W(CNT_W)) u_cnt (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .inc   (bus.event_i),
    .dec   (issue),
    .cnt   (cnt),
    .full  (full),
    .empty (empty),
    .drop  (drop)
  );
  // handshake FSM: toggle once, wait for busy to rise then fall; a missing rise is flagged, not retried
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    data_d  = data_q;
    issue   = 1'b0;
    err_set = 1'b0;
    case (state_q)
      IDLE: if (!empty && !bus.cdc_busy_i) begin
        issue   = 1'b1;
        data_d  = ~data_q;
        timer_d = '0;
        state_d = WAIT_RISE;
      end
      WAIT_RISE: if (bus.cdc_busy_i) state_d = WAIT_FALL;
        else if (timer_q == TW'(RISE_WAIT - 1)) begin
          err_set = 1'b1;
          state_d = IDLE;
        end else timer_d = timer_q + TW'(1);
      WAIT_FALL: if (!bus.cdc_busy_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ovf_d = drop || (ovf_q && !bus.clear_err_i);
    err_d = err_set || (err_q && !bus.clear_err_i);
  end
  // state, timer, toggle line and sticky flags
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      timer_q <= '0;
      data_q  <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end
  assign bus.data_o     = data_q;
  assign bus.pending_o  = cnt;
  assign bus.idle_o     = state_q == IDLE && empty;
  assign bus.overflow_o = ovf_q;
  assign bus.ack_err_o  = err_q;
endmodule
